// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the machine-mode trap sequencer: CSR
// addresses, sequencer states and MSTATUS bit positions.
package pack;

    // CSR addresses reachable through the CSR file's read/write ports
    typedef enum logic [11:0] {
        MSTATUS  = 12'h300,
        MISA     = 12'h301,
        MIE      = 12'h304,
        MTVEC    = 12'h305,
        MSCRATCH = 12'h340,
        MEPC     = 12'h341,
        MCAUSE   = 12'h342,
        MTVAL    = 12'h343,
        MIP      = 12'h344,
        MCYCLE   = 12'hB00,
        MINSTRET = 12'hB02
    } destinationCSR_;

    // E_* states walk trap entry, R_* states walk mret
    typedef enum logic [2:0] {
        IDLE,
        E_MEPC,
        E_MCAUSE,
        E_MTVAL,
        E_MSTATUS,
        E_REDIRECT,
        R_MSTATUS,
        R_REDIRECT
    } trapState_;

    // MSTATUS field positions; MPP occupies [MSTATUS_MPP+1:MSTATUS_MPP]
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 11;

    // MCAUSE for an external machine interrupt
    localparam logic [31:0] INT_CAUSE_DEFAULT = 32'h8000000B;

endpackage

// File: rtl/trap_sequencer.sv
// Machine-mode trap / interrupt / mret sequencer. Owns the CSR file's single
// read and write port while it spills MEPC, MCAUSE, MTVAL and MSTATUS one per
// cycle, stalls the pipeline meanwhile, and finishes with a fetch redirect.
module trap_sequencer
    import pack::*;
#(
    parameter logic [31:0] INT_CAUSE = INT_CAUSE_DEFAULT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           interrupt,
    input  logic           excValid,
    input  logic [4:0]     excCause,
    input  logic [31:0]    excPC,
    input  logic [31:0]    excTval,
    input  logic           mretValid,
    input  logic [31:0]    intPC,
    input  logic           pipeWriteEnable,
    input  destinationCSR_ pipeDestination,
    input  logic [31:0]    pipeWriteData,
    input  destinationCSR_ pipeReadCSR,
    input  logic [31:0]    csrReadData,
    input  logic [31:0]    trapVector,
    output destinationCSR_ readCSR,
    output destinationCSR_ destinationCSR,
    output logic [31:0]    csrWriteData,
    output logic           csrDestinationEnable,
    output logic           stall,
    output logic           redirectValid,
    output logic [31:0]    redirectPC
);

    trapState_   state;
    trapState_   next_state;
    logic [31:0] pc_lat;
    logic [31:0] cause_lat;
    logic [31:0] tval_lat;
    logic        mie_shadow;

    logic        take_exc;
    logic        take_mret;
    logic        take_int;
    logic        pipe_write;

    // Trap entry: stack MIE into MPIE, disable interrupts, previous mode = M
    function automatic logic [31:0] entry_mstatus(input logic [31:0] cur);
        logic [31:0] v;
        v                    = cur;
        v[MSTATUS_MPIE]      = cur[MSTATUS_MIE];
        v[MSTATUS_MIE]       = 1'b0;
        v[MSTATUS_MPP +: 2]  = 2'b11;
        return v;
    endfunction

    // mret: restore MIE from MPIE, set MPIE, MPP stays M (only M-mode exists)
    function automatic logic [31:0] mret_mstatus(input logic [31:0] cur);
        logic [31:0] v;
        v                    = cur;
        v[MSTATUS_MIE]       = cur[MSTATUS_MPIE];
        v[MSTATUS_MPIE]      = 1'b1;
        v[MSTATUS_MPP +: 2]  = 2'b11;
        return v;
    endfunction

    // Vectored mode only offsets interrupts; exceptions always use the base
    function automatic logic [31:0] trap_target(input logic [31:0] tvec,
                                                input logic [31:0] cause);
        logic [31:0] base;
        base = tvec & ~32'h3;
        if (tvec[1:0] == 2'b01 && cause[31])
            return base + {25'b0, cause[4:0], 2'b00};
        return base;
    endfunction

    // Event acceptance in IDLE: exception > mret > enabled interrupt.
    // The interrupt enable is the registered shadow, never a same-cycle write.
    assign take_exc   = (state == IDLE) && excValid;
    assign take_mret  = (state == IDLE) && !excValid && mretValid;
    assign take_int   = (state == IDLE) && !excValid && !mretValid && interrupt && mie_shadow;

    // A faulting instruction must not retire its own CSR write
    assign pipe_write = pipeWriteEnable && !excValid;

    // Moore outputs straight from the state register
    assign stall         = (state != IDLE);
    assign redirectValid = (state == E_REDIRECT) || (state == R_REDIRECT);

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Capture PC / cause / tval of the accepted trap for the spill states
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_lat    <= '0;
            cause_lat <= '0;
            tval_lat  <= '0;
        end else if (take_exc) begin
            pc_lat    <= excPC;
            cause_lat <= {27'b0, excCause};
            tval_lat  <= excTval;
        end else if (take_int) begin
            pc_lat    <= intPC;
            cause_lat <= INT_CAUSE;
            tval_lat  <= '0;
        end
    end

    // Mirror of MSTATUS.MIE, fed by whichever source writes MSTATUS
    always_ff @(posedge clock) begin
        if (reset)
            mie_shadow <= 1'b0;
        else if (csrDestinationEnable && destinationCSR == MSTATUS)
            mie_shadow <= csrWriteData[MSTATUS_MIE];
    end

    // Next state and CSR port mux: pass-through in IDLE, sequencer-owned otherwise
    always_comb begin
        next_state           = state;
        readCSR              = pipeReadCSR;
        destinationCSR       = pipeDestination;
        csrWriteData         = '0;
        csrDestinationEnable = 1'b0;
        redirectPC           = '0;

        unique case (state)
            IDLE: begin
                csrDestinationEnable = pipe_write;
                csrWriteData         = pipe_write ? pipeWriteData : 32'h0;
                if (take_exc || take_int)
                    next_state = E_MEPC;
                else if (take_mret)
                    next_state = R_MSTATUS;
            end
            E_MEPC: begin
                readCSR              = MSTATUS;
                destinationCSR       = MEPC;
                csrWriteData         = pc_lat & ~32'h3;
                csrDestinationEnable = 1'b1;
                next_state           = E_MCAUSE;
            end
            E_MCAUSE: begin
                readCSR              = MSTATUS;
                destinationCSR       = MCAUSE;
                csrWriteData         = cause_lat;
                csrDestinationEnable = 1'b1;
                next_state           = E_MTVAL;
            end
            E_MTVAL: begin
                readCSR              = MSTATUS;
                destinationCSR       = MTVAL;
                csrWriteData         = tval_lat;
                csrDestinationEnable = 1'b1;
                next_state           = E_MSTATUS;
            end
            E_MSTATUS: begin
                readCSR              = MSTATUS;
                destinationCSR       = MSTATUS;
                csrWriteData         = entry_mstatus(csrReadData);
                csrDestinationEnable = 1'b1;
                next_state           = E_REDIRECT;
            end
            E_REDIRECT: begin
                readCSR    = MSTATUS;
                redirectPC = trap_target(trapVector, cause_lat);
                next_state = IDLE;
            end
            R_MSTATUS: begin
                readCSR              = MSTATUS;
                destinationCSR       = MSTATUS;
                csrWriteData         = mret_mstatus(csrReadData);
                csrDestinationEnable = 1'b1;
                next_state           = R_REDIRECT;
            end
            R_REDIRECT: begin
                readCSR    = MEPC;
                redirectPC = csrReadData & ~32'h3;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

- Sequences machine-mode trap entry, interrupt entry and `mret` onto the CSR file's single read and write ports.
- Muxes those ports between the pipeline and its own multi-cycle writes to MEPC, MCAUSE, MTVAL and MSTATUS.
- Stalls the pipeline while it works, then issues a PC redirect.
- Sits between the pipeline's CSR stage and the CSR file.

## Interface

Parameters:
- `INT_CAUSE`, default `32'h8000000B`: MCAUSE value written for an external interrupt.

Ports (single clock; synchronous active-high reset):
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `interrupt` in 1: level external interrupt request.
- `excValid`, `excCause[4:0]`, `excPC[31:0]`, `excTval[31:0]` in: exception report from the faulting instruction.
- `mretValid` in 1: `mret` reached commit.
- `intPC` in 32: PC of the oldest uncommitted instruction, saved to MEPC on an interrupt.
- `pipeWriteEnable` in 1, `pipeDestination` in `destinationCSR_`, `pipeWriteData` in 32: pipeline CSR write request.
- `pipeReadCSR` in `destinationCSR_`: pipeline CSR read address.
- `csrReadData` in 32: CSR file read data.
- `trapVector` in 32: MTVEC from the CSR file.
- `readCSR`, `destinationCSR` out `destinationCSR_`; `csrWriteData` out 32; `csrDestinationEnable` out 1: drive the CSR file.
- `stall` out 1: freezes the pipeline.
- `redirectValid` out 1, `redirectPC` out 32: one-cycle fetch redirect.

## Operation

- States: IDLE, E_MEPC, E_MCAUSE, E_MTVAL, E_MSTATUS, E_REDIRECT, R_MSTATUS, R_REDIRECT.

IDLE behaviour:
- CSR ports pass straight through from the pipeline.
- Acceptance priority is `excValid` > `mretValid` > (`interrupt` && `mieShadow`).
- Exception: the same-cycle pipeline write is suppressed (enable forced 0). The sequencer latches `excPC`, cause `{27'b0, excCause}` and `excTval`.
- mret: the same-cycle pipeline write commits. Next state is R_MSTATUS.
- Interrupt: the same-cycle pipeline write commits. The sequencer latches `intPC`, `INT_CAUSE` and tval 0.
- Exception and interrupt go to E_MEPC.

Trap entry sequence (`stall`=1 in every non-IDLE state; one CSR write per state):
- E_MEPC: writes `pc & ~3`.
- E_MCAUSE: writes the latched cause.
- E_MTVAL: writes the latched tval.
- E_MSTATUS: `readCSR`=MSTATUS; writes `csrReadData` with MPIE(7) ← MIE(3), MIE ← 0, MPP[12:11] ← 2'b11.
- E_REDIRECT: `redirectValid`=1, then → IDLE. `redirectPC` is selected as follows:
  - Default is `trapVector & ~3`.
  - If `trapVector[1:0]==2'b01` and cause bit 31 is set, it is `(trapVector & ~3) + 4*cause[4:0]` (32-bit, wraps).

mret sequence:
- R_MSTATUS: reads MSTATUS; writes MIE ← MPIE, MPIE ← 1, MPP ← 2'b11.
- R_REDIRECT: `readCSR`=MEPC; `redirectPC = csrReadData & ~3`; `redirectValid`=1, then → IDLE.

`mieShadow` register:
- Tracks MSTATUS bit 3.
- Loads `csrWriteData[3]` on any cycle where `csrDestinationEnable && destinationCSR==MSTATUS`, from either source.
- The interrupt check uses the registered value, never the same-cycle write.

Sequence behaviour:
- During a sequence, pipeline write and read requests are ignored. The pipeline holds them under `stall`.
- `interrupt`, `excValid` and `mretValid` are ignored until the sequencer is back in IDLE.
- Unused write-port fields are driven with `destinationCSR`=`pipeDestination` and data 0 when the enable is 0.

## Timing

- Reset state: IDLE, `mieShadow`=0, latches 0, `stall`=0, `redirectValid`=0, `redirectPC`=0, `csrDestinationEnable`=0.
- Reset mid-sequence aborts in the next cycle. There are no partial-write guarantees beyond writes already done.
- Trap accepted at cycle N: writes land at N+1..N+4; redirect at N+5; IDLE at N+6. `stall` is high N+1..N+5.
- mret accepted at N: MSTATUS write at N+1; redirect at N+2; IDLE at N+3.
- `stall` and `redirectValid` are Moore outputs (from the state register only).
- CSR port outputs are combinational from state, latches and pipeline inputs. There is no added read latency.
- Back-to-back: a new event can be accepted in the IDLE cycle immediately after a redirect.
- The MCYCLE/MINSTRET side effects inside the CSR file are unaffected. Only write contention rules apply.

## Structure

- In `pack`: `trapState_` enum, `MSTATUS_MIE`/`MPIE`/`MPP` bit-position localparams, and the default `INT_CAUSE`.
- MEPC, MCAUSE and MTVAL are members of `destinationCSR_`.
- Single module, no sub-module; the state register plus a port mux is all it needs.

## Test plan

- Exception, cause 2, `excPC`=`0x100`, tval `0xDEAD`, MTVEC=`0x200`, plus a simultaneous pipeline write to MSCRATCH:
  - MEPC=`0x100`, MCAUSE=2, MTVAL=`0xDEAD`, MSTATUS=`0x1800`.
  - Redirect to `0x200` at N+5; MSCRATCH unchanged.
- Pipeline writes MSTATUS=`0x1808`, then the interrupt rises one cycle later with MTVEC=`0x301`:
  - Entry taken; MCAUSE=`0x8000000B`; MSTATUS=`0x1880`.
  - `redirectPC`=`0x32C`.
- Interrupt with `mieShadow`=0 (post-reset): no stall and no writes for 20 cycles.
- After the interrupt entry above, mret: MSTATUS=`0x1888`, redirect to the saved `intPC` at N+2, `mieShadow`=1.
- `excValid`, `mretValid` and `interrupt` all in one cycle: the exception wins; `mret` is ignored and not replayed.
- Reset asserted in E_MCAUSE: the next cycle is IDLE with all outputs 0, and the following trap sequences normally.
